// File: rtl/mips_run_ctrl_if.sv
// Trace readout bus of the MIPS run controller.
// The reader (master) pops entries; the controller (slave) returns data,
// a one-cycle valid pulse and the current fill level.
interface mips_run_ctrl_if #(
    parameter int PC_W        = 32,
    parameter int TRACE_DEPTH = 16
);
    logic                           trace_rd_en;
    logic [PC_W-1:0]                trace_rd_data;
    logic                           trace_rd_valid;
    logic [$clog2(TRACE_DEPTH):0]   trace_count;

    modport master (
        output trace_rd_en,
        input  trace_rd_data,
        input  trace_rd_valid,
        input  trace_count
    );

    modport slave (
        input  trace_rd_en,
        output trace_rd_data,
        output trace_rd_valid,
        output trace_count
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS pipeline core: sequences core reset, watches
// current_pc and ends the run on halt-PC hit, PC stall or cycle timeout.
// Optional circular PC trace is built only when RUN_CTRL_TRACE_EN is defined;
// otherwise the trace bus reads back constant zeros.
module mips_run_ctrl #(
    parameter int PC_W         = 32,
    parameter int RESET_CYCLES = 4,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_W        = 24,
    parameter int TRACE_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   halt_pc,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic [PC_W-1:0]   current_pc,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  cycle_count,
    mips_run_ctrl_if.slave    trace
);
    localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_RST, ST_RUN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [RST_W-1:0]   rst_cnt_reg;
    logic [STALL_W-1:0] stall_cnt_reg;
    logic [PC_W-1:0]    prev_pc_reg;
    logic [1:0]         status_reg;
    logic [CNT_W-1:0]   cycle_count_reg;
    logic [CNT_W-1:0]   cycle_inc;
    logic               pc_same, stall_hit, timeout_hit;
    logic               enter_rst, run_end;
    logic [1:0]         end_status;

    assign cycle_inc   = cycle_count_reg + CNT_W'(1);
    assign pc_same     = (current_pc == prev_pc_reg);
    // The counter holds the number of earlier matches; this cycle's match
    // brings it to STALL_LIMIT-1, i.e. the PC was seen STALL_LIMIT times.
    assign stall_hit   = pc_same && (stall_cnt_reg == STALL_W'(STALL_LIMIT - 2));
    // A saturated counter wraps cycle_inc to 0, which never matches a live timeout.
    assign timeout_hit = (timeout_cycles != '0) && (cycle_inc == timeout_cycles);

    assign status      = status_reg;
    assign cycle_count = cycle_count_reg;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next state, end-cause priority and state-decoded outputs
    always_comb begin
        state_next = state_reg;
        core_reset = 1'b1;
        running    = 1'b0;
        done       = 1'b0;
        enter_rst  = 1'b0;
        run_end    = 1'b0;
        end_status = 2'd0;
        if (current_pc == halt_pc) end_status = 2'd1;
        else if (stall_hit)        end_status = 2'd2;
        else if (timeout_hit)      end_status = 2'd3;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RST;
                    enter_rst  = 1'b1;
                end
            end
            ST_RST: begin
                if (rst_cnt_reg == RST_W'(RESET_CYCLES - 1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                running    = 1'b1;
                if (end_status != 2'd0) begin
                    run_end    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_RST;
                    enter_rst  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run bookkeeping: reset-hold counter, cycle counter, stall tracking, status latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt_reg     <= '0;
            stall_cnt_reg   <= '0;
            prev_pc_reg     <= '0;
            status_reg      <= 2'd0;
            cycle_count_reg <= '0;
        end else if (enter_rst) begin
            rst_cnt_reg     <= '0;
            stall_cnt_reg   <= '0;
            prev_pc_reg     <= '0;
            status_reg      <= 2'd0;
            cycle_count_reg <= '0;
        end else begin
            if (state_reg == ST_RST) rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
            if (state_reg == ST_RUN) begin
                if (cycle_count_reg != '1) cycle_count_reg <= cycle_inc;
                prev_pc_reg   <= current_pc;
                stall_cnt_reg <= pc_same ? stall_cnt_reg + STALL_W'(1) : '0;
                if (run_end) status_reg <= end_status;
            end
        end
    end

`ifdef RUN_CTRL_TRACE_EN
    localparam int TA_W = $clog2(TRACE_DEPTH);
    localparam int TC_W = TA_W + 1;

    logic [PC_W-1:0] trace_mem [TRACE_DEPTH];
    logic [TA_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [TC_W-1:0] count_reg;
    logic [PC_W-1:0] last_wr_reg, rd_data_reg;
    logic            rd_valid_reg;
    logic            trace_wr, trace_rd, trace_full;

    assign trace_full = (count_reg == TC_W'(TRACE_DEPTH));
    // Empty trace in RUN means this is the first RUN cycle: always record it.
    assign trace_wr   = (state_reg == ST_RUN) &&
                        ((count_reg == '0) || (current_pc != last_wr_reg));
    assign trace_rd   = (state_reg == ST_DONE) && trace.trace_rd_en && (count_reg != '0);

    assign trace.trace_rd_data  = rd_data_reg;
    assign trace.trace_rd_valid = rd_valid_reg;
    assign trace.trace_count    = count_reg;

    // Trace storage, kept reset-free so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (trace_wr) trace_mem[wr_ptr_reg] <= current_pc;
    end

    // Ring pointers, fill level and registered readout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            last_wr_reg  <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else if (enter_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= trace_rd;
            if (trace_rd) begin
                rd_data_reg <= trace_mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + TA_W'(1);
                count_reg   <= count_reg - TC_W'(1);
            end
            if (trace_wr) begin
                last_wr_reg <= current_pc;
                wr_ptr_reg  <= wr_ptr_reg + TA_W'(1);
                // Full: the new entry replaces the oldest, so the oldest moves on.
                if (trace_full) rd_ptr_reg <= rd_ptr_reg + TA_W'(1);
                else            count_reg  <= count_reg + TC_W'(1);
            end
        end
    end
`else
    localparam int TC_W = $clog2(TRACE_DEPTH) + 1;
    logic unused_trace_rd_en;

    assign unused_trace_rd_en   = trace.trace_rd_en;
    assign trace.trace_rd_data  = '0;
    assign trace.trace_rd_valid = 1'b0;
    assign trace.trace_count    = TC_W'(0);
`endif

endmodule
